// File: rtl/reg_file_wb_if.sv
// Operand-read and writeback bundle between the datapath and the register file.
interface reg_file_wb_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned RA = 4
);
    logic [RA-1:0] rd_addrA;
    logic [RA-1:0] rd_addrB;
    logic [DW-1:0] datA_out;
    logic [DW-1:0] datB_out;
    logic          wb_valid;
    logic [RA-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_sc_en;
    logic          wb_sc;
    logic          wb_pari_en;
    logic          wb_pari;
    logic          sc_q;
    logic          pari_q;
    logic          pend_valid;

    modport master (
        output rd_addrA, rd_addrB, wb_valid, wb_addr, wb_data,
        output wb_sc_en, wb_sc, wb_pari_en, wb_pari,
        input  datA_out, datB_out, sc_q, pari_q, pend_valid
    );

    modport slave (
        input  rd_addrA, rd_addrB, wb_valid, wb_addr, wb_data,
        input  wb_sc_en, wb_sc, wb_pari_en, wb_pari,
        output datA_out, datB_out, sc_q, pari_q, pend_valid
    );
endinterface

// File: rtl/reg_file_wb.sv
// Two-read-port register file with a one-entry writeback register and full bypassing,
// plus the shift-carry and parity flags fed back to the ALU.
module reg_file_wb #(
    parameter int unsigned DW = 8,
    parameter int unsigned RA = 4
) (
    input logic         clk,
    input logic         reset_n,
    reg_file_wb_if.slave bus
);
    localparam int unsigned NumRegs = 2 ** RA;

    logic [DW-1:0] regs_q [NumRegs];
    logic          pend_valid_q;
    logic [RA-1:0] pend_addr_q;
    logic [DW-1:0] pend_data_q;
    logic          sc_flag_q;
    logic          pari_flag_q;

    // Old pending value commits on the same edge a new write loads, so same-address
    // back-to-back writes never lose data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            sc_flag_q    <= 1'b0;
            pari_flag_q  <= 1'b0;
        end else begin
            if (pend_valid_q) begin
                regs_q[pend_addr_q] <= pend_data_q;
            end
            pend_valid_q <= bus.wb_valid;
            if (bus.wb_valid) begin
                pend_addr_q <= bus.wb_addr;
                pend_data_q <= bus.wb_data;
                if (bus.wb_sc_en) begin
                    sc_flag_q <= bus.wb_sc;
                end
                if (bus.wb_pari_en) begin
                    pari_flag_q <= bus.wb_pari;
                end
            end
        end
    end

    // Per-port priority: incoming write, then pending write, then array.
    always_comb begin
        bus.datA_out = regs_q[bus.rd_addrA];
        if (bus.wb_valid && (bus.wb_addr == bus.rd_addrA)) begin
            bus.datA_out = bus.wb_data;
        end else if (pend_valid_q && (pend_addr_q == bus.rd_addrA)) begin
            bus.datA_out = pend_data_q;
        end
    end

    always_comb begin
        bus.datB_out = regs_q[bus.rd_addrB];
        if (bus.wb_valid && (bus.wb_addr == bus.rd_addrB)) begin
            bus.datB_out = bus.wb_data;
        end else if (pend_valid_q && (pend_addr_q == bus.rd_addrB)) begin
            bus.datB_out = pend_data_q;
        end
    end

    assign bus.sc_q       = sc_flag_q;
    assign bus.pari_q     = pari_flag_q;
    assign bus.pend_valid = pend_valid_q;
endmodule
